// File: rtl/rd_port_arbiter.sv
// -----------------------------------------------------------------------------
// rd_port_arbiter
//
// Read-domain scheduler for the async FIFO's single read port. It grants the
// port to one of NUM_REQ consumers at a time, in round-robin order, for bursts
// of up to MAX_BURST words. While a consumer holds the grant, the block pops
// the FIFO (rinc) whenever that consumer can accept a word and the FIFO is not
// empty. The popped word is registered and handed to the granted consumer
// with a one-cycle valid strobe.
//
// Ports
//   rclk       in   read-domain clock
//   rrst_n     in   asynchronous active-low reset
//   rempty     in   registered empty flag from the read-pointer logic
//   rdata      in   memory word at the current read address (valid when !rempty)
//   rinc       out  pop strobe to the read-pointer logic (combinational)
//   req        in   per-consumer "can accept a word this cycle"
//   gnt        out  registered one-hot grant, all-zero when idle
//   out_data   out  registered popped word, shared by all consumers
//   out_valid  out  registered per-consumer strobe for out_data
// -----------------------------------------------------------------------------
module rd_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_REQ-1:0]    out_valid
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state_q,     state_d;
  logic [NUM_REQ-1:0]    gnt_q,       gnt_d;
  logic [IDX_W-1:0]      gidx_q,      gidx_d;
  logic [IDX_W-1:0]      last_q,      last_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [NUM_REQ-1:0]    out_valid_q, out_valid_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  others_req;
  logic                  release_burst;

  // Round-robin search: first requester strictly after the last winner,
  // wrapping around, so the last winner itself is considered last.
  always_comb begin : rr_pick
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && req[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // Someone other than the current holder is waiting; used to give the port
  // away when the FIFO runs dry instead of idling on an empty queue.
  assign others_req = |(req & ~gnt_q);

  // NOTE: every output of this block gets a default before the case
  // statement, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    gidx_d        = gidx_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    out_data_d    = out_data_q;
    out_valid_d   = '0;
    rinc          = 1'b0;
    release_burst = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BURST;
          gidx_d  = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          cnt_d   = '0;
        end
      end

      BURST: begin
        rinc = req[gidx_q] & ~rempty;

        if (rinc) begin
          cnt_d       = cnt_q + CNT_W'(1);
          out_data_d  = rdata;
          out_valid_d = gnt_q;
        end

        // A pop on the final burst slot still delivers its word next cycle;
        // only the grant is withdrawn.
        release_burst = (rinc && (cnt_q == CNT_W'(MAX_BURST - 1)))
                     || !req[gidx_q]
                     || (rempty && others_req);

        if (release_burst) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = gidx_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/rd_port_arbiter.md
# rd_port_arbiter

Read-domain scheduler that shares the single read port of the async FIFO among `NUM_REQ` consumers. It sits between the read-pointer/empty logic and the FIFO memory on one side and the consumers on the other. It grants the port to one consumer at a time in bursts of up to `MAX_BURST` words, using round-robin order. It drives `rinc`, captures the memory read data and delivers each word to the granted consumer with a per-consumer valid strobe.

## Interface
- `NUM_REQ`, default 4: number of consumers, ≥2.
- `DATA_WIDTH`, default 8: FIFO word width.
- `MAX_BURST`, default 16: maximum words popped per grant, ≥1.

- `rclk`  in  1  read-domain clock.
- `rrst_n`  in  1  reset, asynchronous, active-low.
- `rempty`  in  1  registered empty flag from the read-pointer logic.
- `rdata`  in  DATA_WIDTH  memory word at the current read address; valid whenever `rempty`=0.
- `rinc`  out  1  pop strobe to the read-pointer logic.
- `req`  in  NUM_REQ  consumer i can accept a word this cycle.
- `gnt`  out  NUM_REQ  registered one-hot grant; all-zero when idle.
- `out_data`  out  DATA_WIDTH  registered popped word, shared by all consumers.
- `out_valid`  out  NUM_REQ  registered strobe; consumer i takes `out_data` when bit i is 1.

## Operation
- Reset values: `gnt`=0, `out_valid`=0, `out_data`=0, state=IDLE, burst count=0, last-winner pointer=`NUM_REQ`-1. `rinc`=0 because it is decoded from state.
- FSM states: IDLE, BURST.
- **IDLE**
  - If `req`≠0, grant the first requester at or after last-winner+1, modulo `NUM_REQ`.
  - Register `gnt`, clear the burst count and go to BURST.
  - If `req`=0, stay in IDLE.
  - `rinc`=0 in IDLE.
- **BURST**, granted index g:
  - `rinc` = `req[g]` & ~`rempty`, combinational.
  - Each cycle with `rinc`=1 is a pop. It increments the burst count. Burst count width is clog2(`MAX_BURST`+1), and the count never exceeds `MAX_BURST`.
- **Release conditions**: any one of the following sends BURST to IDLE at the next edge.
  - The current cycle is a pop and the count reaches `MAX_BURST`.
  - `req[g]`=0.
  - `rempty`=1 and some other `req` bit is 1 (work-conserving release).
- On release:
  - `gnt` clears.
  - last-winner becomes g.
- `rempty`=1 with no other requester pending: grant is held and `rinc`=0.
- Delivery: on every pop, the following cycle has `out_data` = the `rdata` sampled at the pop, and `out_valid` = `gnt` of the pop cycle. `out_data` holds its value on non-pop cycles.
- `out_valid` has at most one bit set, and only on the cycle after a pop.
- Simultaneous pop and release: the pop completes and its word is delivered to g the next cycle, even though `gnt` has already cleared.
- Reset mid-burst: all registers clear immediately. A pop only occurs at a clock edge with `rinc`=1, so a word whose pop edge never happened stays in the FIFO. A word popped on the edge just before reset is lost, which is acceptable.

## Timing
- Grant latency: `req` rises in IDLE → `gnt` at the next edge → first `rinc` in that same following cycle if not empty.
- Data latency: pop at cycle N → `out_valid`/`out_data` at cycle N+1.
- Steady-state throughput: 1 word/cycle within a burst.
- Arbitration overhead: exactly 1 idle cycle between consecutive grants.
- Maximum wait for a persistently requesting consumer: (`NUM_REQ`-1) × (`MAX_BURST`+2) cycles plus FIFO-empty time.
- The `req` → `rinc` path is combinational. The `rempty` → `rinc` path is combinational. All other outputs are registered.

## Test plan
- **Reset**: assert `rrst_n`=0 mid-burst with `rinc` active → `gnt`=0, `out_valid`=0 and `rinc`=0 immediately. After release, req0 wins the first grant.
- **Round-robin**: FIFO holds 64 words, `MAX_BURST`=16, `req`=4'b1111 constant → grants in order 0,1,2,3,0. Each burst is exactly 16 consecutive pops, with 1 idle cycle between bursts.
- **Data ordering**: words 0x00..0x0F written, only req2 asserted → `out_valid[2]` pulses 16 times. `out_data` = 0x00..0x0F in order, each 1 cycle after its pop.
- **Early release**: req1 drops after 5 pops → `gnt` clears the next edge and exactly 5 words are delivered to consumer 1. The next grant goes to the lowest requester after 1.
- **Empty handling**:
  - FIFO empties mid-burst with only req0 active → `gnt` held, `rinc`=0, and pops resume when `rempty` falls.
  - Same situation with req3 also active → release, then grant to 3.
- **Pop on last cycle**: 16th pop coincides with `req[g]` falling → that word is still delivered with `out_valid[g]`=1, and no 17th pop occurs.
